// File: rtl/iob_pkg.sv
// Shared constants and types for the PDP-6 I/O-bus character output slave.
package iob_pkg;

    localparam logic [6:0] DEV_TTY_OUT = 7'o12;
    localparam logic [6:0] DEV_PTP     = 7'o10;

    // Bus bit numbering is PDP-6 style: bit 0 is the MSB, bit 35 the LSB.
    localparam int IOB_ST_BUSY    = 30;
    localparam int IOB_ST_DONE    = 31;
    localparam int IOB_ST_PIA_LSB = 33;
    localparam int IOB_DATA_MSB   = 28;
    localparam int IOB_DATA_LSB   = 35;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic logic [1:7] pi_decode(input logic [2:0] level);
        logic [1:7] v;
        v = '0;
        if (level != 3'd0) v[level] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/iob_ser_out_ser_tx_shift.sv
// Async serial transmitter: start bit, 8 data bits LSB first, STOPBITS stop bits.
module ser_tx_shift
    import iob_pkg::*;
#(
    parameter int unsigned CLKDIV   = 16,
    parameter int unsigned STOPBITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] char_in,
    output logic       busy,
    output logic       fin,
    output logic       ser_out
);

    tx_state_e   state, state_n;
    logic [15:0] div_cnt, div_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shreg, shreg_n;
    logic        tick;

    assign tick = (div_cnt == 16'(CLKDIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= TX_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        fin     = 1'b0;
        if (clr) begin
            state_n = TX_IDLE;
            div_n   = '0;
            bit_n   = '0;
        end else begin
            // fin reflects the end of the current frame even when a load restarts it
            case (state)
                TX_IDLE: ;
                TX_START: begin
                    if (tick) begin
                        div_n   = '0;
                        bit_n   = '0;
                        state_n = TX_DATA;
                    end else div_n = div_cnt + 16'd1;
                end
                TX_DATA: begin
                    if (tick) begin
                        div_n   = '0;
                        shreg_n = shreg >> 1;
                        if (bit_cnt == 3'd7) begin
                            bit_n   = '0;
                            state_n = TX_STOP;
                        end else bit_n = bit_cnt + 3'd1;
                    end else div_n = div_cnt + 16'd1;
                end
                TX_STOP: begin
                    if (tick) begin
                        div_n = '0;
                        if (bit_cnt == 3'(STOPBITS - 1)) begin
                            state_n = TX_IDLE;
                            fin     = 1'b1;
                        end else bit_n = bit_cnt + 3'd1;
                    end else div_n = div_cnt + 16'd1;
                end
                default: state_n = TX_IDLE;
            endcase
            if (load) begin
                state_n = TX_START;
                div_n   = '0;
                bit_n   = '0;
                shreg_n = char_in;
            end
        end
    end

    assign busy = (state != TX_IDLE);

    always_comb begin
        case (state)
            TX_START: ser_out = 1'b0;
            TX_DATA:  ser_out = shreg[0];
            default:  ser_out = 1'b1;
        endcase
    end

endmodule

// File: rtl/iob_ser_out.sv
// PDP-6 I/O-bus character-serial output slave (DATAO/CONO/CONI/DATAI, PI request).
// Define SER_OUT_DBUF_EN to add a holding register behind the shifter.
module iob_ser_out
    import iob_pkg::*;
#(
    parameter logic [6:0]  DEV      = DEV_TTY_OUT,
    parameter int unsigned CLKDIV   = 16,
    parameter int unsigned STOPBITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iob_poweron,
    input  logic        iob_reset,
    input  logic        datao_clear,
    input  logic        datao_set,
    input  logic        cono_clear,
    input  logic        cono_set,
    input  logic        iob_fm_datai,
    input  logic        iob_fm_status,
    input  logic        rdi_pulse,
    input  logic [3:9]  ios,
    input  logic [0:35] iob_write,
    output logic [1:7]  pi_req,
    output logic [0:35] iob_read,
    output logic        dr_split,
    output logic        rdi_data,
    output logic        ser_out
);

    logic       sel, bus_clr, wr;
    logic [0:7] char_buf, wr_char;
    logic [2:0] pia;
    logic       done, done_n, busy;
    logic       tx_busy, tx_fin, tx_load;
    logic [7:0] tx_char;
    logic       unused;

    assign sel      = (ios == DEV);
    assign bus_clr  = iob_reset | ~iob_poweron;
    assign wr       = sel & datao_set;
    assign wr_char  = ((sel & datao_clear) ? '0 : char_buf) | iob_write[IOB_DATA_MSB:IOB_DATA_LSB];
    assign dr_split = 1'b0;
    assign rdi_data = 1'b0;
    assign unused   = ^{rdi_pulse, iob_write[0:27]};

`ifdef SER_OUT_DBUF_EN
    logic [7:0] hold_char, hold_char_n;
    logic       hold_full, hold_full_n;

    assign busy = tx_busy | hold_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_char <= '0;
            hold_full <= 1'b0;
        end else if (bus_clr) begin
            hold_char <= '0;
            hold_full <= 1'b0;
        end else begin
            hold_char <= hold_char_n;
            hold_full <= hold_full_n;
        end
    end
`else
    assign busy = tx_busy;
`endif

    always_comb begin
        tx_load = 1'b0;
        tx_char = wr_char;
        done_n  = done;
        if (tx_fin) done_n = 1'b1;
`ifdef SER_OUT_DBUF_EN
        hold_char_n = hold_char;
        hold_full_n = hold_full;
        if (tx_fin && hold_full) begin
            tx_load     = 1'b1;
            tx_char     = hold_char;
            hold_full_n = 1'b0;
        end
        // A write only bypasses the holding register when the shifter is free this cycle
        if (wr) begin
            if (tx_busy && !(tx_fin && !hold_full)) begin
                hold_char_n = wr_char;
                hold_full_n = 1'b1;
                done_n      = 1'b0;
            end else begin
                tx_load = 1'b1;
                tx_char = wr_char;
                done_n  = 1'b1;
            end
        end
`else
        if (wr) begin
            tx_load = 1'b1;
            done_n  = 1'b0;
        end
`endif
        if (sel && cono_clear) done_n = 1'b0;
        if (sel && cono_set && iob_write[IOB_ST_DONE]) done_n = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            char_buf <= '0;
            pia      <= '0;
            done     <= 1'b0;
            pi_req   <= '0;
        end else if (bus_clr) begin
            char_buf <= '0;
            pia      <= '0;
            done     <= 1'b0;
            pi_req   <= '0;
        end else begin
            if (wr) char_buf <= wr_char;
            else if (sel && datao_clear) char_buf <= '0;
            pia <= ((sel && cono_clear) ? 3'd0 : pia)
                 | ((sel && cono_set) ? iob_write[IOB_ST_PIA_LSB:IOB_DATA_LSB] : 3'd0);
            done   <= done_n;
            pi_req <= done ? pi_decode(pia) : '0;
        end
    end

    ser_tx_shift #(
        .CLKDIV  (CLKDIV),
        .STOPBITS(STOPBITS)
    ) u_tx (
        .clk    (clk),
        .reset  (reset),
        .clr    (bus_clr),
        .load   (tx_load),
        .char_in(tx_char),
        .busy   (tx_busy),
        .fin    (tx_fin),
        .ser_out(ser_out)
    );

    always_comb begin
        iob_read = '0;
        if (sel && iob_fm_status) begin
            iob_read[IOB_ST_BUSY]                  = busy;
            iob_read[IOB_ST_DONE]                  = done;
            iob_read[IOB_ST_PIA_LSB:IOB_DATA_LSB]  = pia;
        end
        if (sel && iob_fm_datai)
            iob_read[IOB_DATA_MSB:IOB_DATA_LSB] = iob_read[IOB_DATA_MSB:IOB_DATA_LSB] | char_buf;
    end

endmodule
